// File: rtl/if_id_pkg.sv
// Shared definitions for the IF/ID pipeline register.
//   - state_t       : occupancy state of the stage (EMPTY / BUSY / FULL)
//   - NOP_DEFAULT   : default instruction word driven when no entry is held
//   - entry_width() : width of one packed {pc, npc, instr} entry
package if_id_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    // One entry is packed as {pc, npc, instr}.
    function automatic int entry_width(input int width);
        return 3 * width;
    endfunction

endpackage

// File: rtl/if_id_entry_reg.sv
// Enable-loaded register holding one packed {pc, npc, instr} entry.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : synchronous load of the empty entry {0, 0, NOP}; wins over load
//   load       : capture d on the rising edge
//   d          : incoming entry {pc, npc, instr}
//   q          : held entry {pc, npc, instr}
module if_id_entry_reg
    import if_id_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] NOP   = WIDTH'(NOP_DEFAULT)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    input  logic                            load,
    input  logic [entry_width(WIDTH)-1:0]   d,
    output logic [entry_width(WIDTH)-1:0]   q
);

    localparam logic [entry_width(WIDTH)-1:0] EMPTY_ENTRY = {{(2*WIDTH){1'b0}}, NOP};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= EMPTY_ENTRY;
        end else if (clear) begin
            q <= EMPTY_ENTRY;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_id_stage_register.sv
// IF/ID pipeline register with a two-entry skid buffer.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   in_valid / in_ready             : fetch-side handshake (in_ready is registered)
//   in_pc, in_npc, in_instr         : fetched entry
//   out_valid / out_ready           : decode-side handshake
//   out_pc, out_npc, out_instr      : held entry ({0, 0, NOP} when out_valid is low)
//   flush                           : synchronous discard of held and incoming entries
//   stall_cnt                       : saturating count of cycles with out_valid & !out_ready
module if_id_stage_register
    import if_id_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] NOP   = WIDTH'(NOP_DEFAULT),
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_npc,
    input  logic [WIDTH-1:0] in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_npc,
    output logic [WIDTH-1:0] out_instr,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int EW = entry_width(WIDTH);

    state_t          state;
    state_t          state_next;
    logic            main_load;
    logic            main_clear;
    logic            main_from_skid;
    logic            skid_load;
    logic [EW-1:0]   in_entry;
    logic [EW-1:0]   main_d;
    logic [EW-1:0]   main_q;
    logic [EW-1:0]   skid_q;

    assign in_entry = {in_pc, in_npc, in_instr};
    assign main_d   = main_from_skid ? skid_q : in_entry;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (in_valid) state_next = ST_BUSY;
            ST_BUSY: begin
                if (in_valid && !out_ready)      state_next = ST_FULL;
                else if (!in_valid && out_ready) state_next = ST_EMPTY;
            end
            ST_FULL:  if (out_ready) state_next = ST_BUSY;
            default:  state_next = ST_EMPTY;
        endcase
        if (flush) state_next = ST_EMPTY;
    end

    // Output and datapath control. The main register is cleared whenever the
    // stage becomes empty, so the out_* ports read {0, 0, NOP} straight from
    // the register without an output mux.
    always_comb begin
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            ST_EMPTY: begin
                in_ready  = 1'b1;
                main_load = in_valid;
            end
            ST_BUSY: begin
                in_ready   = 1'b1;
                out_valid  = 1'b1;
                main_load  = in_valid && out_ready;
                skid_load  = in_valid && !out_ready;
                main_clear = !in_valid && out_ready;
            end
            ST_FULL: begin
                out_valid      = 1'b1;
                main_load      = out_ready;
                main_from_skid = out_ready;
            end
            default: begin
                main_clear = 1'b1;
            end
        endcase
        if (flush) begin
            main_clear = 1'b1;
            main_load  = 1'b0;
            skid_load  = 1'b0;
        end
    end

    if_id_entry_reg #(
        .WIDTH (WIDTH),
        .NOP   (NOP)
    ) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (main_clear),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    if_id_entry_reg #(
        .WIDTH (WIDTH),
        .NOP   (NOP)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .load  (skid_load),
        .d     (in_entry),
        .q     (skid_q)
    );

    assign {out_pc, out_npc, out_instr} = main_q;

    // Stall counter: saturates at all ones, only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_if_id_stage_register.sv
// Self-checking bench for if_id_stage_register: a scoreboard queue is filled
// by the stimulus on every accepted upstream transfer and drained by a
// monitor on every downstream transfer; directed checks cover handshake,
// flush, reset and the stall counter.
module tb_if_id_stage_register;

    localparam int          WIDTH = 32;
    localparam int          CNT_W = 4;
    localparam logic [31:0] NOPV  = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] instr;
    } entry_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_pc = '0;
    logic [WIDTH-1:0] in_npc = '0;
    logic [WIDTH-1:0] in_instr = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_npc;
    logic [WIDTH-1:0] out_instr;
    logic             flush = 1'b0;
    logic [CNT_W-1:0] stall_cnt;

    entry_t sb[$];
    int     n_checks = 0;
    int     n_errors = 0;

    always #5 clk = ~clk;

    if_id_stage_register #(
        .WIDTH (WIDTH),
        .NOP   (NOPV),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_npc    (in_npc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_npc   (out_npc),
        .out_instr (out_instr),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one cycle of stimulus (called at posedge+1, returns at next posedge+1).
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic ordy, input logic fl, output logic acc);
        in_valid  = v;
        in_pc     = pc;
        in_npc    = pc + 32'd4;
        in_instr  = instr;
        out_ready = ordy;
        flush     = fl;
        acc = v && in_ready && !fl;
        if (acc) sb.push_back('{pc: pc, npc: pc + 32'd4, instr: instr});
        @(posedge clk);
        #1;
    endtask

    // Monitor: downstream transfers are compared against the scoreboard;
    // empty-stage outputs must read {0, 0, NOP}.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got pc %0h instr %0h required none", out_pc, out_instr);
            end else begin
                entry_t e;
                e = sb.pop_front();
                check("out_pc", out_pc, e.pc);
                check("out_npc", out_npc, e.npc);
                check("out_instr", out_instr, e.instr);
            end
        end else if (!out_valid) begin
            check("idle_out_instr", out_instr, NOPV);
            check("idle_out_pc", out_pc, 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;

        // Reset state
        #12;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_npc", out_npc, 32'h0);
        check("rst_stall_cnt", {28'b0, stall_cnt}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming at full throughput
        drive(1, 32'h00, 32'hA0, 1, 0, acc);
        check("lat_out_valid", {31'b0, out_valid}, 32'd1);
        check("stream_in_ready0", {31'b0, in_ready}, 32'd1);
        drive(1, 32'h04, 32'hA1, 1, 0, acc);
        check("stream_in_ready1", {31'b0, in_ready}, 32'd1);
        drive(1, 32'h08, 32'hA2, 1, 0, acc);
        check("stream_in_ready2", {31'b0, in_ready}, 32'd1);
        drive(0, 32'h0, 32'h0, 1, 0, acc);
        check("stream_drained", {31'b0, out_valid}, 32'd0);

        // Backpressure and skid
        drive(1, 32'h10, 32'hB0, 0, 0, acc);
        check("bp_busy_in_ready", {31'b0, in_ready}, 32'd1);
        drive(1, 32'h14, 32'hB1, 0, 0, acc);
        check("bp_full_in_ready", {31'b0, in_ready}, 32'd0);
        drive(1, 32'h18, 32'hB2, 0, 0, acc);
        check("bp_0x18_rejected", {31'b0, acc}, 32'd0);
        drive(1, 32'h18, 32'hB2, 1, 0, acc);
        check("bp_drain_rejected", {31'b0, acc}, 32'd0);
        check("bp_in_ready_back", {31'b0, in_ready}, 32'd1);
        drive(1, 32'h18, 32'hB2, 1, 0, acc);
        check("bp_0x18_accepted", {31'b0, acc}, 32'd1);
        drive(0, 32'h0, 32'h0, 1, 0, acc);
        check("bp_drained", {31'b0, out_valid}, 32'd0);

        // Flush while FULL with an incoming entry
        drive(1, 32'h20, 32'hC0, 0, 0, acc);
        drive(1, 32'h24, 32'hC1, 0, 0, acc);
        drive(1, 32'h28, 32'hC2, 0, 1, acc);
        sb.delete();
        check("flush_full_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_full_out_instr", out_instr, NOPV);
        check("flush_full_in_ready", {31'b0, in_ready}, 32'd1);
        drive(0, 32'h0, 32'h0, 1, 0, acc);
        drive(0, 32'h0, 32'h0, 1, 0, acc);

        // Flush while BUSY with an acceptable incoming entry
        drive(1, 32'h30, 32'hD0, 0, 0, acc);
        drive(1, 32'h34, 32'hD1, 0, 1, acc);
        sb.delete();
        check("flush_busy_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_busy_out_pc", out_pc, 32'h0);
        drive(0, 32'h0, 32'h0, 1, 0, acc);
        drive(1, 32'h38, 32'hD2, 1, 0, acc);
        drive(0, 32'h0, 32'h0, 1, 0, acc);

        // Asynchronous reset while FULL
        drive(1, 32'h50, 32'hE0, 0, 0, acc);
        drive(1, 32'h54, 32'hE1, 0, 0, acc);
        check("pre_rst_in_ready", {31'b0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        check("midrst_out_instr", out_instr, NOPV);
        check("midrst_stall_cnt", {28'b0, stall_cnt}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stall counter saturation
        drive(1, 32'h40, 32'hF0, 0, 0, acc);
        for (int i = 0; i < 5; i++) drive(0, 32'h0, 32'h0, 0, 0, acc);
        check("stall_cnt_5", {28'b0, stall_cnt}, 32'd5);
        for (int i = 0; i < 15; i++) drive(0, 32'h0, 32'h0, 0, 0, acc);
        check("stall_cnt_sat", {28'b0, stall_cnt}, 32'd15);
        drive(0, 32'h0, 32'h0, 0, 0, acc);
        check("stall_cnt_hold", {28'b0, stall_cnt}, 32'd15);
        drive(0, 32'h0, 32'h0, 0, 1, acc);
        sb.delete();
        check("stall_cnt_flush", {28'b0, stall_cnt}, 32'd15);
        check("stall_flush_out_valid", {31'b0, out_valid}, 32'd0);
        drive(0, 32'h0, 32'h0, 1, 0, acc);
        check("stall_cnt_after", {28'b0, stall_cnt}, 32'd15);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
